// File: rtl/pmod_cls_line_pkg.sv
// Shared constants and state encoding for the multi-line CLS command scheduler.
package pmod_cls_line_pkg;

    localparam logic [7:0] ESC    = 8'h1B;
    localparam logic [7:0] LBRK   = 8'h5B;
    localparam logic [7:0] CLR    = 8'h6A;
    localparam logic [7:0] SEMI   = 8'h3B;
    localparam logic [7:0] HOME   = 8'h48;
    localparam logic [7:0] ASCII0 = 8'h30;
    localparam logic [7:0] SPACE  = 8'h20;

    localparam int unsigned HDR_LEN = 6;
    localparam int unsigned CLR_LEN = 3;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_LOAD_CLR,
        ST_LOAD_LINE,
        ST_GO,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE
    } t_cls_sched_state;

endpackage

// File: rtl/pmod_cls_pending_arbiter.sv
// Lowest-set-bit finder over the pending line mask.
module pmod_cls_pending_arbiter
    import pmod_cls_line_pkg::*;
#(
    parameter int unsigned LINES = 2
) (
    input  logic [LINES-1:0] pend,
    output logic [3:0]       idx_c,
    output logic             valid_c
);

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        idx_c   = 4'hF;
        valid_c = 1'b0;
        for (int i = int'(LINES) - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx_c   = 4'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmod_cls_line_scheduler.sv
// N-line CLS escape-sequence generator feeding the generic SPI engine's TX FIFO,
// with clear, masked line writes and changed-line auto-refresh.
module pmod_cls_line_scheduler
    import pmod_cls_line_pkg::*;
#(
    parameter int unsigned parm_fast_simulation = 0,
    parameter int unsigned FCLK                 = 20000000,
    parameter int unsigned FCLK_ce              = 2500000,
    parameter int unsigned parm_line_count      = 2,
    parameter int unsigned parm_line_chars      = 16,
    parameter int unsigned parm_tx_len_bits     = 11,
    parameter int unsigned parm_wait_cyc_bits   = 2,
    parameter int unsigned parm_rx_len_bits     = 11
) (
    input  logic                                           i_clk_20mhz,
    input  logic                                           i_rstn_20mhz,
    input  logic                                           i_ce_2_5mhz,
    output logic                                           o_go_stand,
    input  logic                                           i_spi_idle,
    output logic [parm_tx_len_bits-1:0]                    o_tx_len,
    output logic [parm_wait_cyc_bits-1:0]                  o_wait_cyc,
    output logic [parm_rx_len_bits-1:0]                    o_rx_len,
    output logic [7:0]                                     o_tx_data,
    output logic                                           o_tx_enqueue,
    input  logic                                           i_tx_ready,
    output logic                                           o_command_ready,
    input  logic                                           i_cmd_clear,
    input  logic [parm_line_count-1:0]                     i_cmd_wr_lines,
    input  logic                                           i_auto_refresh,
    input  logic [parm_line_count*parm_line_chars*8-1:0]   i_dat_ascii,
    output logic [3:0]                                     o_active_line
);

    localparam int unsigned LINES    = parm_line_count;
    localparam int unsigned CHARS    = parm_line_chars;
    localparam int unsigned LINE_LEN = HDR_LEN + CHARS;
    localparam int unsigned IDX_W    = $clog2(LINE_LEN + 1);
    localparam int unsigned CHAR_W   = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam int unsigned LSEL_W   = (LINES > 1) ? $clog2(LINES) : 1;
    // 100 ms of system clock expressed in CE pulses.
    localparam int unsigned BOOT_CE  = (parm_fast_simulation != 0) ? 16 :
                                       (FCLK / 10) / (FCLK / FCLK_ce);
    localparam int unsigned BOOT_W   = $clog2(BOOT_CE + 1);

    t_cls_sched_state state, state_nxt;

    logic [BOOT_W-1:0]           boot_cnt, boot_cnt_nxt;
    logic [IDX_W-1:0]            byte_idx, byte_idx_nxt;
    logic [3:0]                  cur_line, cur_line_nxt;
    logic                        serving_line, serving_line_nxt;
    logic [LINES-1:0]            pend, pend_nxt, diff;
    logic                        clr_pend, clr_pend_nxt;
    logic                        snap_load, lw_load, cmd_present;
    logic [CHARS-1:0][7:0]       live [LINES];
    logic [CHARS-1:0][7:0]       snap [LINES];
    logic [CHARS-1:0][7:0]       lw   [LINES];
    logic [3:0]                  arb_idx;
    logic                        arb_valid;
    logic                        go_nxt, enq_nxt, ready_nxt;
    logic [7:0]                  data_nxt, line_byte, clr_byte;
    logic [parm_tx_len_bits-1:0] tx_len_nxt;
    logic [3:0]                  active_nxt;
    logic [CHAR_W-1:0]           char_sel;
    logic [LSEL_W-1:0]           line_sel;

    pmod_cls_pending_arbiter #(.LINES(LINES)) u_arbiter (
        .pend    (pend),
        .idx_c   (arb_idx),
        .valid_c (arb_valid)
    );

    assign o_wait_cyc  = '0;
    assign o_rx_len    = '0;
    assign cmd_present = i_cmd_clear | (|i_cmd_wr_lines);
    assign line_sel    = cur_line[LSEL_W-1:0];
    assign char_sel    = CHAR_W'(CHARS - 1) - CHAR_W'(byte_idx - IDX_W'(HDR_LEN));

    // Unpack live text per line (char 0 in the MSB byte) and flag changed lines.
    always_comb begin
        diff = '0;
        for (int l = 0; l < int'(LINES); l++) begin
            live[l] = i_dat_ascii[l*CHARS*8 +: CHARS*8];
            diff[l] = (live[l] != lw[l]);
        end
    end

    always_comb begin
        line_byte = snap[line_sel][char_sel];
        case (byte_idx)
            IDX_W'(0): line_byte = ESC;
            IDX_W'(1): line_byte = LBRK;
            IDX_W'(2): line_byte = ASCII0 + 8'(cur_line);
            IDX_W'(3): line_byte = SEMI;
            IDX_W'(4): line_byte = ASCII0;
            IDX_W'(5): line_byte = HOME;
            default:   ;
        endcase
        clr_byte = (byte_idx == IDX_W'(0)) ? ESC :
                   (byte_idx == IDX_W'(1)) ? LBRK : CLR;
    end

    // Next-state and next-output logic; everything is committed on CE.
    always_comb begin
        state_nxt        = state;
        boot_cnt_nxt     = boot_cnt;
        byte_idx_nxt     = byte_idx;
        cur_line_nxt     = cur_line;
        serving_line_nxt = serving_line;
        pend_nxt         = pend;
        clr_pend_nxt     = clr_pend;
        snap_load        = 1'b0;
        lw_load          = 1'b0;
        go_nxt           = 1'b0;
        enq_nxt          = 1'b0;
        data_nxt         = o_tx_data;
        tx_len_nxt       = o_tx_len;
        active_nxt       = o_active_line;

        case (state)
            ST_BOOT: begin
                if (boot_cnt == BOOT_W'(BOOT_CE - 1)) state_nxt = ST_IDLE;
                else boot_cnt_nxt = boot_cnt + BOOT_W'(1);
            end
            ST_IDLE: begin
                active_nxt = 4'hF;
                if (clr_pend) begin
                    state_nxt        = ST_LOAD_CLR;
                    byte_idx_nxt     = '0;
                    serving_line_nxt = 1'b0;
                    tx_len_nxt       = parm_tx_len_bits'(CLR_LEN);
                end else if (arb_valid) begin
                    state_nxt        = ST_LOAD_LINE;
                    byte_idx_nxt     = '0;
                    serving_line_nxt = 1'b1;
                    cur_line_nxt     = arb_idx;
                    active_nxt       = arb_idx;
                    tx_len_nxt       = parm_tx_len_bits'(LINE_LEN);
                end else if (o_command_ready && cmd_present) begin
                    clr_pend_nxt = i_cmd_clear;
                    pend_nxt     = pend | i_cmd_wr_lines;
                    snap_load    = 1'b1;
                end else if (i_auto_refresh && (diff != '0)) begin
                    pend_nxt  = pend | diff;
                    snap_load = 1'b1;
                end
            end
            ST_LOAD_CLR: begin
                if (i_tx_ready) begin
                    enq_nxt  = 1'b1;
                    data_nxt = clr_byte;
                    if (byte_idx == IDX_W'(CLR_LEN - 1)) state_nxt = ST_GO;
                    else byte_idx_nxt = byte_idx + IDX_W'(1);
                end
            end
            ST_LOAD_LINE: begin
                if (i_tx_ready) begin
                    enq_nxt  = 1'b1;
                    data_nxt = line_byte;
                    if (byte_idx == IDX_W'(LINE_LEN - 1)) state_nxt = ST_GO;
                    else byte_idx_nxt = byte_idx + IDX_W'(1);
                end
            end
            ST_GO: begin
                go_nxt    = 1'b1;
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!i_spi_idle) state_nxt = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (i_spi_idle) begin
                    state_nxt = ST_IDLE;
                    if (serving_line) begin
                        pend_nxt = pend & ~(LINES'(1) << cur_line);
                        lw_load  = 1'b1;
                    end else begin
                        clr_pend_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = ST_BOOT;
        endcase

        // Ready only after a full CE period in idle with nothing queued.
        ready_nxt = (state == ST_IDLE) && (state_nxt == ST_IDLE) &&
                    (pend_nxt == '0) && !clr_pend_nxt && i_spi_idle;
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (!i_rstn_20mhz) begin
            state           <= ST_BOOT;
            boot_cnt        <= '0;
            byte_idx        <= '0;
            cur_line        <= '0;
            serving_line    <= 1'b0;
            pend            <= '0;
            clr_pend        <= 1'b0;
            o_go_stand      <= 1'b0;
            o_tx_len        <= '0;
            o_tx_data       <= '0;
            o_tx_enqueue    <= 1'b0;
            o_command_ready <= 1'b0;
            o_active_line   <= 4'hF;
        end else if (i_ce_2_5mhz) begin
            state           <= state_nxt;
            boot_cnt        <= boot_cnt_nxt;
            byte_idx        <= byte_idx_nxt;
            cur_line        <= cur_line_nxt;
            serving_line    <= serving_line_nxt;
            pend            <= pend_nxt;
            clr_pend        <= clr_pend_nxt;
            o_go_stand      <= go_nxt;
            o_tx_len        <= tx_len_nxt;
            o_tx_data       <= data_nxt;
            o_tx_enqueue    <= enq_nxt;
            o_command_ready <= ready_nxt;
            o_active_line   <= active_nxt;
        end
    end

    // Snapshot of the commanded text and copy of what the display currently shows.
    always_ff @(posedge i_clk_20mhz) begin
        if (!i_rstn_20mhz) begin
            for (int l = 0; l < int'(LINES); l++) begin
                snap[l] <= {CHARS{SPACE}};
                lw[l]   <= {CHARS{SPACE}};
            end
        end else if (i_ce_2_5mhz) begin
            if (snap_load) begin
                for (int l = 0; l < int'(LINES); l++) snap[l] <= live[l];
            end
            if (lw_load) lw[line_sel] <= snap[line_sel];
        end
    end

endmodule

// File: tb/tb_pmod_cls_line_scheduler.sv
// Directed bench for the CLS line scheduler: boot, clear, multi-line, backpressure,
// auto-refresh and mid-transfer reset, against a small SPI-engine stand-in.
module tb_pmod_cls_line_scheduler;

    localparam int unsigned LINES = 2;
    localparam int unsigned CHARS = 16;

    logic                     clk;
    logic                     rstn;
    logic                     ce;
    logic                     go_stand;
    logic                     spi_idle;
    logic [10:0]              tx_len;
    logic [1:0]               wait_cyc;
    logic [10:0]              rx_len;
    logic [7:0]               tx_data;
    logic                     tx_enqueue;
    logic                     tx_ready;
    logic                     command_ready;
    logic                     cmd_clear;
    logic [LINES-1:0]         cmd_wr_lines;
    logic                     auto_refresh;
    logic [LINES*CHARS*8-1:0] dat_ascii;
    logic [3:0]               active_line;

    int n_cmp;
    int n_err;
    int ce_div;
    int spi_cnt;
    bit ce_hit;

    logic [7:0] byte_q [$];
    logic [7:0] exp_q  [$];
    int         go_len_q  [$];
    int         go_line_q [$];

    logic [CHARS*8-1:0] l0, l1;

    pmod_cls_line_scheduler #(
        .parm_fast_simulation (1),
        .parm_line_count      (LINES),
        .parm_line_chars      (CHARS)
    ) dut (
        .i_clk_20mhz     (clk),
        .i_rstn_20mhz    (rstn),
        .i_ce_2_5mhz     (ce),
        .o_go_stand      (go_stand),
        .i_spi_idle      (spi_idle),
        .o_tx_len        (tx_len),
        .o_wait_cyc      (wait_cyc),
        .o_rx_len        (rx_len),
        .o_tx_data       (tx_data),
        .o_tx_enqueue    (tx_enqueue),
        .i_tx_ready      (tx_ready),
        .o_command_ready (command_ready),
        .i_cmd_clear     (cmd_clear),
        .i_cmd_wr_lines  (cmd_wr_lines),
        .i_auto_refresh  (auto_refresh),
        .i_dat_ascii     (dat_ascii),
        .o_active_line   (active_line)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    initial ce_div = 0;
    always @(negedge clk) begin
        ce_div = (ce_div + 1) % 8;
        ce     = (ce_div == 0);
    end

    always @(posedge clk) ce_hit = ce && rstn;

    // Log enqueued bytes / go pulses and emulate the SPI engine's idle handshake.
    always @(negedge clk) begin
        if (!rstn) begin
            spi_cnt  = 0;
            spi_idle = 1'b1;
        end else begin
            if (ce_hit && tx_enqueue) byte_q.push_back(tx_data);
            if (ce_hit && go_stand) begin
                go_len_q.push_back(int'(tx_len));
                go_line_q.push_back(int'(active_line));
                spi_cnt = 1;
            end else if (spi_cnt != 0) begin
                spi_cnt++;
                if (spi_cnt == 12) spi_idle = 1'b0;
                if (spi_cnt == 40) begin
                    spi_idle = 1'b1;
                    spi_cnt  = 0;
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ce_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (ce !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic release_and_boot(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        rstn = 1'b1;
        while (k < 40 && command_ready !== 1'b1) begin
            ce_wait(1);
            k++;
        end
        check_eq(tag, k, 17);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int k;
        k = 0;
        while (k < budget && command_ready !== 1'b1) begin
            ce_wait(1);
            k++;
        end
        check_eq({tag, "_ready"}, command_ready, 1);
    endtask

    task automatic issue(input logic clr, input logic [LINES-1:0] wr);
        cmd_clear    = clr;
        cmd_wr_lines = wr;
        ce_wait(1);
        cmd_clear    = 1'b0;
        cmd_wr_lines = '0;
    endtask

    task automatic clear_logs();
        byte_q.delete();
        exp_q.delete();
        go_len_q.delete();
        go_line_q.delete();
    endtask

    task automatic push_clr();
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h5B);
        exp_q.push_back(8'h6A);
    endtask

    task automatic push_line(input int r, input logic [CHARS*8-1:0] txt);
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h5B);
        exp_q.push_back(8'(8'h30 + r));
        exp_q.push_back(8'h3B);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h48);
        for (int k = 0; k < int'(CHARS); k++) exp_q.push_back(txt[(int'(CHARS) - 1 - k)*8 +: 8]);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check_eq({tag, "_bytes"}, byte_q.size(), exp_q.size());
        n = (byte_q.size() < exp_q.size()) ? byte_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq($sformatf("%s_b%0d", tag, i), byte_q[i], exp_q[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_go"},      go_stand,      0);
        check_eq({tag, "_enq"},     tx_enqueue,    0);
        check_eq({tag, "_data"},    tx_data,       0);
        check_eq({tag, "_len"},     tx_len,        0);
        check_eq({tag, "_ready"},   command_ready, 0);
        check_eq({tag, "_waitcyc"}, wait_cyc,      0);
        check_eq({tag, "_rxlen"},   rx_len,        0);
        check_eq({tag, "_line"},    active_line,   4'hF);
    endtask

    initial begin
        int k;
        n_cmp        = 0;
        n_err        = 0;
        rstn         = 1'b0;
        tx_ready     = 1'b1;
        cmd_clear    = 1'b0;
        cmd_wr_lines = '0;
        auto_refresh = 1'b0;
        dat_ascii    = {LINES*CHARS{8'h20}};

        repeat (20) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        release_and_boot("boot_ce_count");

        // Clear only.
        clear_logs();
        issue(1'b1, '0);
        check_eq("clr_ready_drop", command_ready, 0);
        wait_ready("clr", 200);
        check_eq("clr_spi_idle", spi_idle, 1);
        push_clr();
        compare_stream("clr");
        check_eq("clr_go_count", go_len_q.size(), 1);
        if (go_len_q.size() > 0) check_eq("clr_go_len", go_len_q[0], 3);

        // Clear plus both lines in one command.
        l0 = "0123456789abcdef";
        l1 = "ABCDEFGHIJKLMNOP";
        dat_ascii = {l1, l0};
        clear_logs();
        issue(1'b1, 2'b11);
        wait_ready("sim", 500);
        push_clr();
        push_line(0, l0);
        push_line(1, l1);
        compare_stream("sim");
        check_eq("sim_go_count", go_len_q.size(), 3);
        if (go_len_q.size() == 3) begin
            check_eq("sim_len0", go_len_q[0], 3);
            check_eq("sim_len1", go_len_q[1], 22);
            check_eq("sim_len2", go_len_q[2], 22);
            check_eq("sim_line0", go_line_q[0], 15);
            check_eq("sim_line1", go_line_q[1], 0);
            check_eq("sim_line2", go_line_q[2], 1);
        end

        // Backpressure after the 7th byte of a line-0 write.
        l0 = "ZYXWVUTSRQPONMLK";
        dat_ascii = {l1, l0};
        clear_logs();
        issue(1'b0, 2'b01);
        k = 0;
        while (k < 400 && byte_q.size() < 7) begin
            @(negedge clk);
            #1;
            k++;
        end
        tx_ready = 1'b0;
        ce_wait(5);
        check_eq("bp_hold_count", byte_q.size(), 7);
        check_eq("bp_hold_enq", tx_enqueue, 0);
        tx_ready = 1'b1;
        wait_ready("bp", 300);
        push_line(0, l0);
        compare_stream("bp");
        check_eq("bp_go_count", go_len_q.size(), 1);

        // Auto-refresh: quiet while unchanged, then exactly one line-1 rewrite.
        clear_logs();
        auto_refresh = 1'b1;
        ce_wait(20);
        check_eq("ar_quiet_bytes", byte_q.size(), 0);
        check_eq("ar_quiet_ready", command_ready, 1);
        l1 = "ABCxEFGHIJKLMNOP";
        dat_ascii = {l1, l0};
        k = 0;
        while (k < 20 && command_ready === 1'b1) begin
            ce_wait(1);
            k++;
        end
        check_eq("ar_busy", command_ready, 0);
        wait_ready("ar", 300);
        push_line(1, l1);
        compare_stream("ar");
        check_eq("ar_go_count", go_len_q.size(), 1);
        if (go_line_q.size() > 0) check_eq("ar_go_line", go_line_q[0], 1);
        ce_wait(20);
        check_eq("ar_after_bytes", byte_q.size(), 22);
        auto_refresh = 1'b0;

        // Reset asserted right after the 10th byte of a line-1 write.
        l1 = "RESETRESETRESETX";
        dat_ascii = {l1, l0};
        clear_logs();
        issue(1'b0, 2'b10);
        k = 0;
        while (k < 400 && byte_q.size() < 10) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq("mid_bytes_seen", byte_q.size(), 10);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst");
        repeat (16) @(posedge clk);
        #1;
        check_eq("mid_rst_no_more", byte_q.size(), 10);
        release_and_boot("reboot_ce_count");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pmod_cls_line_scheduler.md
Name: pmod_cls_line_scheduler

Overview:
- Parametrised successor to the fixed two-line CLS command driver. Supports N display lines of C characters, a write-mask command, a clear command, and an auto-refresh mode that rewrites only lines whose text has changed.
- Generates the CLS escape-sequence byte stream and drives the existing pmod_generic_spi_solo user interface (go/idle/tx FIFO). This replaces pmod_cls_stand_spi_solo in the CLS driver wrapper.
- The FSM advances only on the 4x-SPI clock enable.

Parameters:
- parm_fast_simulation, 0, 1 = boot delay of 16 CE pulses instead of FCLK_ce/10 (100 ms)
- FCLK, 20000000, i_clk_20mhz frequency in Hz
- FCLK_ce, 2500000, i_ce_2_5mhz pulse rate in Hz
- parm_line_count, 2, number of display lines, 1..9
- parm_line_chars, 16, characters per line, 1..32
- parm_tx_len_bits, 11, width of o_tx_len
- parm_wait_cyc_bits, 2, width of o_wait_cyc
- parm_rx_len_bits, 11, width of o_rx_len

Ports:
- i_clk_20mhz  in  1  system clock
- i_rstn_20mhz  in  1  synchronous reset, active-low
- i_ce_2_5mhz  in  1  clock enable, 4x SPI bit rate
- o_go_stand  out  1  one-CE pulse that starts an SPI transaction
- i_spi_idle  in  1  SPI engine idle
- o_tx_len  out  parm_tx_len_bits  bytes in current transaction
- o_wait_cyc  out  parm_wait_cyc_bits  constant 0
- o_rx_len  out  parm_rx_len_bits  constant 0
- o_tx_data  out  8  byte to enqueue
- o_tx_enqueue  out  1  enqueue strobe, qualified by CE
- i_tx_ready  in  1  TX FIFO can accept
- o_command_ready  out  1  idle and able to accept commands
- i_cmd_clear  in  1  clear display
- i_cmd_wr_lines  in  parm_line_count  mask of lines to write
- i_auto_refresh  in  1  enable changed-line refresh
- i_dat_ascii  in  parm_line_count*parm_line_chars*8  line text; line 0 in the LSBs; char 0 in the MSB byte of each line
- o_active_line  out  4  line index currently being sent; 15 when none

Behaviour:
- Reset (i_rstn_20mhz=0 on a clock edge): state ST_BOOT.
  - Outputs: all 0 except o_active_line=15.
  - Pending mask, snapshot and last-written buffers are cleared to 0x20 (space).
  - Reset overrides CE. A reset mid-transfer aborts immediately; the SPI engine is reset by the same wrapper reset.
- All state updates occur only when i_ce_2_5mhz=1; outputs hold between CE pulses.
- ST_BOOT: count CE pulses to the boot delay, then go to ST_IDLE.
- ST_IDLE: o_command_ready=1 when the pending mask is 0, no clear is pending, and i_spi_idle=1.
- Command acceptance, on a CE cycle with o_command_ready=1:
  - Latch i_cmd_clear into clr_pend and OR i_cmd_wr_lines into the pending mask.
  - Snapshot all of i_dat_ascii.
  - o_command_ready drops on the next CE cycle.
  - Commands presented while not ready are ignored.
- Auto-refresh:
  - Applies in ST_IDLE when i_auto_refresh=1 and no command is accepted that cycle.
  - Lines whose live i_dat_ascii differs from the last-written buffer set their pending bits, and the snapshot is taken in the same cycle.
- Service priority: clear first, then pending lines in ascending index order.
- ST_LOAD_CLR: enqueue 0x1B,0x5B,0x6A; o_tx_len=3.
- ST_LOAD_LINE (line r):
  - Enqueue 0x1B,0x5B, 0x30+r, 0x3B, 0x30, 0x48, then parm_line_chars snapshot bytes.
  - o_tx_len=6+parm_line_chars; o_active_line=r.
- Enqueue rule: one byte per CE cycle, and only while i_tx_ready=1. If ready drops, the byte index holds and no byte is skipped or duplicated.
- ST_GO: assert o_go_stand for exactly one CE cycle after the last byte, then go to ST_WAIT_BUSY.
- ST_WAIT_BUSY: wait for i_spi_idle=0, then go to ST_WAIT_IDLE.
- ST_WAIT_IDLE: wait for i_spi_idle=1, then:
  - Clear the served pending bit (or clr_pend).
  - For a line, copy its snapshot into the last-written buffer.
  - Return to ST_IDLE, which immediately dispatches the next pending item.
- A clear does not modify the last-written buffer, so auto-refresh does not redraw cleared lines.
- Byte index counter width is clog2(6+parm_line_chars+1). Line index wraps never; the scan is bounded by parm_line_count.

Decomposition:
- Package pmod_cls_line_pkg:
  - Escape constants: ESC=0x1B, LBRK=0x5B, CLR=0x6A, SEMI=0x3B, HOME=0x48, ASCII0=0x30.
  - State enum t_cls_sched_state: ST_BOOT, ST_IDLE, ST_LOAD_CLR, ST_LOAD_LINE, ST_GO, ST_WAIT_BUSY, ST_WAIT_IDLE.
  - Header length constant = 6.
- Sub-module pmod_cls_pending_arbiter: a combinational lowest-set-bit finder over the pending mask, returning index and a valid flag.

Test Plan:
- Boot, fast_sim=1: release reset → o_command_ready rises on the 17th CE pulse, not earlier.
- Clear: pulse i_cmd_clear → bytes 1B 5B 6A, o_tx_len=3, one o_go_stand pulse; ready returns after i_spi_idle 0→1.
- Simultaneous: clear together with i_cmd_wr_lines=2'b11 and line1="ABCDEFGHIJKLMNOP" → clear, then line 0 (1B 5B 30 3B 30 48 +16 bytes, len 22), then line 1 (header 1B 5B 31 3B 30 48 followed by 41..50).
- Backpressure: drop i_tx_ready for 5 CE cycles after byte 7 → the byte stream is continuous with no gap-induced loss or duplicates; total 22 enqueues.
- Auto-refresh: after line 0 is written, change one character of line 1 only with i_auto_refresh=1 → exactly one transaction, for line 1; unchanged input produces no traffic.
- Reset mid-transfer: assert i_rstn_20mhz=0 during byte 10 → next cycle all outputs are 0 and o_active_line=15; the boot delay repeats.
